// File: rtl/hdmi_video_timing_if.sv
// Pixel-request bus and video bus of hdmi_video_timing, with master/slave modports.
// req_valid qualifies req_x/req_y for exactly one cycle. There is no ready: the slave answers with pix_rgb one cycle later, every time.
interface hdmi_video_timing_if;
    logic        req_valid;
    logic [10:0] req_x;
    logic [10:0] req_y;
    logic [23:0] pix_rgb;
    logic [23:0] hdmi_d;
    logic        hdmi_de;
    logic        hdmi_hsync;
    logic        hdmi_vsync;
    logic        frame_start;

    modport master (
        output req_valid, req_x, req_y,
        output hdmi_d, hdmi_de, hdmi_hsync, hdmi_vsync, frame_start,
        input  pix_rgb
    );

    modport slave (
        input  req_valid, req_x, req_y,
        input  hdmi_d, hdmi_de, hdmi_hsync, hdmi_vsync, frame_start,
        output pix_rgb
    );
endinterface

// File: rtl/hdmi_video_timing.sv
// Raster timing and pixel stream for the ADV7511, started by the register-configuration done flag.
// Optional colour-bar generator (adds port test_sel) is enabled by defining HDMI_TEST_PATTERN_EN.
module hdmi_video_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_done,
`ifdef HDMI_TEST_PATTERN_EN
    input  logic                test_sel,
`endif
    output logic                dbg_state,
    hdmi_video_timing_if.master vid
);
    localparam logic [10:0] HA       = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] VA       = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic {WAIT_CFG = 1'b0, RUN = 1'b1} state_t;

    state_t      state;
    logic        run_q;
    logic [10:0] h;
    logic [10:0] v;
    logic        active;
    logic        hs_zone;
    logic        vs_zone;
    logic        s1_hs_n;
    logic        s1_vs_n;
    logic        s1_fs;
    logic        s2_de;
    logic        s2_hs_n;
    logic        s2_vs_n;
    logic        s2_fs;
    logic [23:0] pix_sel;

    assign dbg_state = state;

    // run_q lags the state by one edge so (0,0) reaches the request stage two edges after cfg_done is seen.
    assign active  = run_q && (h < HA) && (v < VA);
    assign hs_zone = run_q && (h >= HS_START) && (h < HS_END);
    assign vs_zone = run_q && (v >= VS_START) && (v < VS_END);

`ifdef HDMI_TEST_PATTERN_EN
    localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

    logic [10:0] s2_x;
    logic [10:0] bar_q;
    logic [2:0]  bar_idx;
    logic [23:0] bar_rgb;

    always_comb begin
        bar_q   = s2_x / BAR_W;
        bar_idx = (bar_q > 11'd7) ? 3'd7 : bar_q[2:0];
        case (bar_idx)
            3'd0:    bar_rgb = 24'hFFFFFF;
            3'd1:    bar_rgb = 24'hFFFF00;
            3'd2:    bar_rgb = 24'h00FFFF;
            3'd3:    bar_rgb = 24'h00FF00;
            3'd4:    bar_rgb = 24'hFF00FF;
            3'd5:    bar_rgb = 24'hFF0000;
            3'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase
    end

    assign pix_sel = test_sel ? bar_rgb : vid.pix_rgb;
`else
    assign pix_sel = vid.pix_rgb;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= WAIT_CFG;
            run_q           <= 1'b0;
            h               <= 11'd0;
            v               <= 11'd0;
            vid.req_valid   <= 1'b0;
            vid.req_x       <= 11'd0;
            vid.req_y       <= 11'd0;
            s1_hs_n         <= 1'b1;
            s1_vs_n         <= 1'b1;
            s1_fs           <= 1'b0;
            s2_de           <= 1'b0;
            s2_hs_n         <= 1'b1;
            s2_vs_n         <= 1'b1;
            s2_fs           <= 1'b0;
`ifdef HDMI_TEST_PATTERN_EN
            s2_x            <= 11'd0;
`endif
            vid.hdmi_d      <= 24'h0;
            vid.hdmi_de     <= 1'b0;
            vid.hdmi_hsync  <= 1'b1;
            vid.hdmi_vsync  <= 1'b1;
            vid.frame_start <= 1'b0;
        end else begin
            case (state)
                WAIT_CFG: if (cfg_done) state <= RUN;
                RUN:      state <= RUN;
                default:  state <= WAIT_CFG;
            endcase
            run_q <= (state == RUN);

            if (run_q) begin
                if (h == H_LAST) begin
                    h <= 11'd0;
                    v <= (v == V_LAST) ? 11'd0 : v + 11'd1;
                end else begin
                    h <= h + 11'd1;
                end
            end

            // Request stage: the address leaves one cycle ahead of the pixel it fetches.
            vid.req_valid <= active;
            vid.req_x     <= active ? h : 11'd0;
            vid.req_y     <= active ? v : 11'd0;
            s1_hs_n       <= ~hs_zone;
            s1_vs_n       <= ~vs_zone;
            s1_fs         <= run_q && (h == 11'd0) && (v == 11'd0);

            // Alignment stage covers the source's read latency.
            s2_de   <= vid.req_valid;
            s2_hs_n <= s1_hs_n;
            s2_vs_n <= s1_vs_n;
            s2_fs   <= s1_fs;
`ifdef HDMI_TEST_PATTERN_EN
            s2_x    <= vid.req_x;
`endif

            vid.hdmi_d      <= s2_de ? pix_sel : 24'h0;
            vid.hdmi_de     <= s2_de;
            vid.hdmi_hsync  <= s2_hs_n;
            vid.hdmi_vsync  <= s2_vs_n;
            vid.frame_start <= s2_fs;
        end
    end
endmodule
